// File: rtl/snake_pkg.sv
// Shared direction encoding for the snake game datapath.
package snake_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'b00;
  localparam dir_t DIR_DOWN  = 2'b01;
  localparam dir_t DIR_LEFT  = 2'b10;
  localparam dir_t DIR_RIGHT = 2'b11;

  // Opposite pairs differ only in bit 0 (up/down, left/right).
  function automatic dir_t opposite_dir(input dir_t d);
    return d ^ 2'b01;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchronizer, stable-level debouncer, press pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Bring the raw button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive differing cycles; any return to the old level restarts.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      level_d = sync2_q;
      press_d = sync2_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Debounced level, counter and registered press pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/dir_input_ctrl.sv
// Direction input controller: debounced buttons feed a 2-entry turn queue
// drained on each snake advance. Define DIR_REVERSE_GUARD_EN to reject
// 180-degree reversals in addition to duplicate directions.
module dir_input_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250
) (
  input  logic       SYS_CLK,
  input  logic       RST,
  input  logic       BTN_UP,
  input  logic       BTN_DOWN,
  input  logic       BTN_LEFT,
  input  logic       BTN_RIGHT,
  input  logic       MOVE_TICK,
  input  logic       ISPAUSED,
  output logic [1:0] MOVE_DIR,
  output logic       TURN_APPLIED,
  output logic [1:0] QUEUE_LEVEL
);

  logic [3:0] btn_raw;
  logic [3:0] press;

  dir_t       move_dir_q, move_dir_d;
  dir_t       q0_q, q0_d, q1_q, q1_d;
  logic [1:0] level_q, level_d, level_after_pop;
  logic       turn_q, turn_d;

  logic       press_vld, pop, push, reverse_ok;
  dir_t       press_dir, ref_dir;

  assign btn_raw = {BTN_RIGHT, BTN_LEFT, BTN_DOWN, BTN_UP};

  // One debouncer per button; bit order gives the priority order.
  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (SYS_CLK),
      .rst_n  (RST),
      .btn_i  (btn_raw[i]),
      .press_o(press[i])
    );
  end

  // Resolve same-cycle presses: UP > DOWN > LEFT > RIGHT.
  always_comb begin
    press_vld = 1'b1;
    press_dir = DIR_UP;
    if (press[0])      press_dir = DIR_UP;
    else if (press[1]) press_dir = DIR_DOWN;
    else if (press[2]) press_dir = DIR_LEFT;
    else if (press[3]) press_dir = DIR_RIGHT;
    else               press_vld = 1'b0;
  end

  // Compare against the last queued turn, or the applied direction if empty.
  always_comb begin
    ref_dir = move_dir_q;
    if (level_q == 2'd2)      ref_dir = q1_q;
    else if (level_q == 2'd1) ref_dir = q0_q;
  end

`ifdef DIR_REVERSE_GUARD_EN
  assign reverse_ok = (press_dir != opposite_dir(ref_dir));
`else
  assign reverse_ok = 1'b1;
`endif

  assign pop             = MOVE_TICK && !ISPAUSED && (level_q != 2'd0);
  assign level_after_pop = level_q - 2'(pop);
  assign push            = press_vld && !ISPAUSED && (level_after_pop != 2'd2)
                           && (press_dir != ref_dir) && reverse_ok;

  // Queue next state: pop shifts head out, push lands behind what remains.
  always_comb begin
    move_dir_d = move_dir_q;
    q0_d       = q0_q;
    q1_d       = q1_q;
    turn_d     = pop;
    level_d    = level_after_pop + 2'(push);
    if (pop) begin
      move_dir_d = q0_q;
      q0_d       = q1_q;
    end
    if (push) begin
      if (level_after_pop == 2'd0) q0_d = press_dir;
      else                         q1_d = press_dir;
    end
  end

  // Applied direction, queue storage and turn pulse.
  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      move_dir_q <= DIR_UP;
      q0_q       <= DIR_UP;
      q1_q       <= DIR_UP;
      level_q    <= 2'd0;
      turn_q     <= 1'b0;
    end else begin
      move_dir_q <= move_dir_d;
      q0_q       <= q0_d;
      q1_q       <= q1_d;
      level_q    <= level_d;
      turn_q     <= turn_d;
    end
  end

  assign MOVE_DIR     = move_dir_q;
  assign TURN_APPLIED = turn_q;
  assign QUEUE_LEVEL  = level_q;

endmodule

// File: tb/tb_dir_input_ctrl.sv
// Directed bench for dir_input_ctrl with DEBOUNCE_CYCLES=4.
module tb_dir_input_ctrl;

  localparam int unsigned DEB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn;            // {RIGHT, LEFT, DOWN, UP}
  logic       move_tick;
  logic       paused;
  logic [1:0] move_dir;
  logic       turn_applied;
  logic [1:0] queue_level;

  int n_cmp  = 0;
  int n_fail = 0;

  dir_input_ctrl #(.DEBOUNCE_CYCLES(DEB)) dut (
    .SYS_CLK     (clk),
    .RST         (rst_n),
    .BTN_UP      (btn[0]),
    .BTN_DOWN    (btn[1]),
    .BTN_LEFT    (btn[2]),
    .BTN_RIGHT   (btn[3]),
    .MOVE_TICK   (move_tick),
    .ISPAUSED    (paused),
    .MOVE_DIR    (move_dir),
    .TURN_APPLIED(turn_applied),
    .QUEUE_LEVEL (queue_level)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Hold a button pattern long enough to register, then release and settle.
  task automatic press_btn(input logic [3:0] b);
    btn = b;
    repeat (DEB + 3) step();
    btn = 4'b0000;
    repeat (DEB + 4) step();
  endtask

  task automatic tick(input string tag, input logic [1:0] exp_dir,
                      input logic exp_turn, input logic [1:0] exp_lvl);
    move_tick = 1'b1;
    step();
    move_tick = 1'b0;
    check({tag, "_dir"}, move_dir, exp_dir);
    check({tag, "_turn"}, {1'b0, turn_applied}, {1'b0, exp_turn});
    check({tag, "_lvl"}, queue_level, exp_lvl);
    step();
    check({tag, "_turn_clr"}, {1'b0, turn_applied}, 2'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    btn       = 4'b0000;
    move_tick = 1'b0;
    paused    = 1'b0;
    repeat (2) step();
    check("rst_dir", move_dir, 2'b00);
    check("rst_turn", {1'b0, turn_applied}, 2'd0);
    check("rst_lvl", queue_level, 2'd0);
    rst_n = 1'b1;
    step();

    // RIGHT held 10 cycles: level appears exactly DEB+3 cycles after the edge.
    btn[3] = 1'b1;
    repeat (DEB + 2) step();
    check("right_lat_early", queue_level, 2'd0);
    step();
    check("right_lat", queue_level, 2'd1);
    repeat (3) step();
    btn[3] = 1'b0;
    repeat (10) step();
    check("right_release", queue_level, 2'd1);
    tick("right_tick", 2'b11, 1'b1, 2'd0);

    // LEFT bouncing every 2 cycles never stabilises.
    for (int i = 0; i < 10; i++) begin
      btn[2] = ~btn[2];
      repeat (2) step();
    end
    repeat (10) step();
    check("bounce_lvl", queue_level, 2'd0);

    // Back to UP, then try the reversal to DOWN.
    press_btn(4'b0001);
    check("up_lvl", queue_level, 2'd1);
    tick("up_tick", 2'b00, 1'b1, 2'd0);
    press_btn(4'b0010);
`ifdef DIR_REVERSE_GUARD_EN
    check("down_rev_lvl", queue_level, 2'd0);
`else
    check("down_rev_lvl", queue_level, 2'd1);
    tick("down_tick", 2'b01, 1'b1, 2'd0);
    press_btn(4'b0001);
    tick("up_back_tick", 2'b00, 1'b1, 2'd0);
`endif

    // LEFT, UP queue; RIGHT dropped on full; two ticks drain in order.
    press_btn(4'b0100);
    check("q_left_lvl", queue_level, 2'd1);
    press_btn(4'b0001);
    check("q_up_lvl", queue_level, 2'd2);
    press_btn(4'b1000);
    check("q_full_lvl", queue_level, 2'd2);
    tick("q_tick1", 2'b10, 1'b1, 2'd1);
    tick("q_tick2", 2'b00, 1'b1, 2'd0);

    // From LEFT, simultaneous UP+RIGHT: only UP is queued.
    press_btn(4'b0100);
    tick("to_left_tick", 2'b10, 1'b1, 2'd0);
    press_btn(4'b1001);
    check("prio_lvl", queue_level, 2'd1);
    tick("prio_tick", 2'b00, 1'b1, 2'd0);

    // Paused: presses dropped, ticks ignored, queue retained.
    press_btn(4'b1000);
    check("pre_pause_lvl", queue_level, 2'd1);
    paused = 1'b1;
    press_btn(4'b0100);
    check("paused_press_lvl", queue_level, 2'd1);
    tick("paused_tick", 2'b00, 1'b0, 2'd1);
    paused = 1'b0;

    // Fill to two with MOVE_DIR non-zero, then reset mid-debounce.
    press_btn(4'b0001);
    check("fill_up_lvl", queue_level, 2'd2);
    tick("fill_tick", 2'b11, 1'b1, 2'd1);
    press_btn(4'b0100);
    check("fill_left_lvl", queue_level, 2'd2);
    btn[3] = 1'b1;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check("async_rst_dir", move_dir, 2'b00);
    check("async_rst_turn", {1'b0, turn_applied}, 2'd0);
    check("async_rst_lvl", queue_level, 2'd0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (DEB + 2) step();
    check("post_rst_early", queue_level, 2'd0);
    step();
    check("post_rst_press", queue_level, 2'd1);
    btn[3] = 1'b0;
    repeat (10) step();
    check("post_rst_dir", move_dir, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
